// File: rtl/game_ctrl_m_if.sv
// Move handshake between a move source and the N x N game controller.
// The source drives valid/loc; the controller answers with ready and a reject pulse.
interface game_ctrl_m_if #(
    parameter int IDX_W = 4
);
    logic             move_valid;
    logic             move_ready;
    logic [IDX_W-1:0] move_loc;
    logic             move_reject;

    modport master (
        output move_valid,
        output move_loc,
        input  move_ready,
        input  move_reject
    );

    modport slave (
        input  move_valid,
        input  move_loc,
        output move_ready,
        output move_reject
    );
endinterface

// File: rtl/game_ctrl_m.sv
// N x N alternating-turn board store with move validation and a sequential
// K-in-a-row checker that examines one direction per cycle around the last move.
module game_ctrl_m #(
    parameter int N     = 3,
    parameter int K     = 3,
    parameter int IDX_W = $clog2(N*N),
    parameter int CNT_W = $clog2(N*N+1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               new_game,
    game_ctrl_m_if.slave       mv,
    output logic [1:0]         turn,
    output logic [2*N*N-1:0]   board_state,
    output logic [CNT_W-1:0]   move_count,
    output logic               game_over,
    output logic [1:0]         winner
);
    localparam int CELLS = N*N;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_dir, w_dir_nxt;
    logic [1:0]       r_board [CELLS];
    logic [1:0]       r_turn;
    logic [1:0]       r_player;
    logic [IDX_W-1:0] r_loc;
    logic [CNT_W-1:0] r_count;
    logic             r_over;
    logic [1:0]       r_winner;
    logic             r_reject;

    logic             w_legal;
    logic             w_accept, w_reject, w_win, w_draw, w_toggle;
    int               w_run;
    logic [2*N*N-1:0] w_board_flat;

    // Off-board positions read as a value no player can own, so runs stop at edges.
    function automatic logic [1:0] cell_at(int rr, int cc);
        if (rr < 0 || rr >= N || cc < 0 || cc >= N)
            return 2'b11;
        return r_board[IDX_W'(rr*N + cc)];
    endfunction

    always_comb begin
        w_legal = 1'b0;
        if (int'(mv.move_loc) < CELLS)
            w_legal = (r_board[mv.move_loc] == 2'b00);
    end

    always_comb begin
        int  row, col, dr, dc;
        logic fwd, bwd;
        row   = int'(r_loc) / N;
        col   = int'(r_loc) % N;
        dr    = 0;
        dc    = 0;
        fwd   = 1'b1;
        bwd   = 1'b1;
        w_run = 1;
        case (r_dir)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        for (int k = 1; k < K; k++) begin
            if (fwd && cell_at(row + dr*k, col + dc*k) == r_player) w_run++;
            else fwd = 1'b0;
            if (bwd && cell_at(row - dr*k, col - dc*k) == r_player) w_run++;
            else bwd = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dir   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_win       = 1'b0;
        w_draw      = 1'b0;
        w_toggle    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mv.move_valid) begin
                    if (w_legal) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_CHECK;
                        w_dir_nxt   = 2'd0;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (w_run >= K) begin
                    w_win       = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_dir == 2'd3) begin
                    if (r_count == CNT_W'(CELLS)) begin
                        w_draw      = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_toggle    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_dir_nxt = r_dir + 2'd1;
                end
            end
            S_DONE:  ;
            default: w_state_nxt = S_IDLE;
        endcase
        // A clear wins over anything the current state wanted to do this cycle.
        if (new_game) begin
            w_state_nxt = S_IDLE;
            w_dir_nxt   = 2'd0;
            w_accept    = 1'b0;
            w_reject    = 1'b0;
            w_win       = 1'b0;
            w_draw      = 1'b0;
            w_toggle    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++) r_board[i] <= 2'b00;
            r_turn   <= 2'b01;
            r_player <= 2'b01;
            r_loc    <= '0;
            r_count  <= '0;
            r_over   <= 1'b0;
            r_winner <= 2'b00;
            r_reject <= 1'b0;
        end else if (new_game) begin
            for (int i = 0; i < CELLS; i++) r_board[i] <= 2'b00;
            r_turn   <= 2'b01;
            r_player <= 2'b01;
            r_loc    <= '0;
            r_count  <= '0;
            r_over   <= 1'b0;
            r_winner <= 2'b00;
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_reject;
            if (w_accept) begin
                r_board[mv.move_loc] <= r_turn;
                r_loc                <= mv.move_loc;
                r_player             <= r_turn;
                r_count              <= r_count + 1'b1;
            end
            if (w_win) begin
                r_over   <= 1'b1;
                r_winner <= r_player;
            end
            if (w_draw) begin
                r_over   <= 1'b1;
                r_winner <= 2'b00;
            end
            if (w_toggle)
                r_turn <= {r_turn[0], r_turn[1]};
        end
    end

    always_comb begin
        w_board_flat = '0;
        for (int i = 0; i < CELLS; i++)
            w_board_flat[2*i +: 2] = r_board[i];
    end

    assign board_state    = w_board_flat;
    assign turn           = r_turn;
    assign move_count     = r_count;
    assign game_over      = r_over;
    assign winner         = r_winner;
    assign mv.move_ready  = (r_state == S_IDLE);
    assign mv.move_reject = r_reject;
endmodule
